serial_frame_loader: RTL

Sequencer that drives the 8-bit MSB-in serial shift register and assembles one FFT input frame from a serial bit stream. Each group of `WORD_W` accepted bits becomes one sample word. Each word is written into the FFT input buffer at a bit-reversed (or natural) address. The block sits between the serial front end and the FFT sample memory, and owns the shift register's `en` and `reset` lines.

---
 rtl/fft_pkg.sv | 27 ++
 rtl/bit_reverse.sv | 13 +
 rtl/serial_frame_loader.sv | 107 ++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT front-end loader: FSM states,
// default word width and a generic address bit-reversal function.
package fft_pkg;

  localparam int unsigned DEF_WORD_W = 8;
  localparam int unsigned MAX_ADDR_W = 10;
  localparam int unsigned IDX_W      = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    WRITE,
    DONE
  } state_t;

  // Reverse the low 'width' bits of value; upper bits of the result are zero.
  function automatic logic [MAX_ADDR_W-1:0] bitrev(input logic [MAX_ADDR_W-1:0] value,
                                                   input int unsigned          width);
    logic [MAX_ADDR_W-1:0] full;
    full = '0;
    for (int unsigned i = 0; i < MAX_ADDR_W; i++) begin
      full[IDX_W'(i)] = value[IDX_W'(MAX_ADDR_W - 1 - i)];
    end
    return full >> (MAX_ADDR_W - width);
  endfunction

endpackage

// File: rtl/bit_reverse.sv
// Combinational bit reversal of an ADDR_W-bit sample index.
module bit_reverse
  import fft_pkg::*;
#(
  parameter int unsigned ADDR_W = 4
) (
  input  logic [ADDR_W-1:0] value,
  output logic [ADDR_W-1:0] reversed
);

  assign reversed = ADDR_W'(bitrev(MAX_ADDR_W'(value), ADDR_W));

endmodule

// File: rtl/serial_frame_loader.sv
// Sequences an external MSB-in shift register to assemble WORD_W-bit samples
// from a serial stream and writes one FFT frame into the sample memory.
module serial_frame_loader
  import fft_pkg::*;
#(
  parameter int unsigned WORD_W    = DEF_WORD_W,
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned ADDR_W    = 4,
  parameter bit          BITREV    = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ser_valid,
  output logic              ser_ready,
  output logic              sr_en,
  output logic              sr_clear,
  input  logic [WORD_W-1:0] shift_word,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned         BIT_CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(WORD_W - 1);
  localparam logic [ADDR_W-1:0]    LAST_SMP = ADDR_W'(FRAME_LEN - 1);

  state_t                 state;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic [ADDR_W-1:0]      smp_cnt;
  logic [ADDR_W-1:0]      smp_rev;
  logic                   ready_q;
  logic                   wr_en_q;

  bit_reverse #(
    .ADDR_W(ADDR_W)
  ) u_bit_reverse (
    .value   (smp_cnt),
    .reversed(smp_rev)
  );

  // Frame sequencer; ready/write/busy/done are registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      smp_cnt    <= '0;
      ready_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          smp_cnt <= '0;
          if (start) begin
            state   <= SHIFT;
            ready_q <= 1'b1;
            busy    <= 1'b1;
          end
        end
        SHIFT: begin
          if (ser_valid) begin
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              state   <= WRITE;
              ready_q <= 1'b0;
              wr_en_q <= 1'b1;
              wr_addr <= BITREV ? smp_rev : smp_cnt;
            end else begin
              bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            end
          end
        end
        WRITE: begin
          wr_en_q <= 1'b0;
          smp_cnt <= (smp_cnt == LAST_SMP) ? '0 : smp_cnt + ADDR_W'(1);
          if (smp_cnt == LAST_SMP) begin
            state      <= DONE;
            frame_done <= 1'b1;
          end else begin
            state   <= SHIFT;
            ready_q <= 1'b1;
          end
        end
        DONE: begin
          frame_done <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Shift-register controls act within the cycle; reset suppresses all of them.
  assign ser_ready = ready_q;
  assign sr_en     = ready_q & ser_valid & ~reset;
  assign sr_clear  = (state == IDLE) & start & ~reset;
  assign wr_en     = wr_en_q & ~reset;
  assign wr_data   = wr_en ? shift_word : '0;

endmodule
